calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Top-level sequencer for the stopwatch-calculator calculator mode. It accepts raw keypad presses, debounces them internally, and assembles two decimal operands plus an operator. On '=' it drives the shared ALU through a start/done handshake, then holds the result for display and supports chained operations. It sits between the keypad decoder and the ALU/7-segment display path.

## Interface
- `DEBOUNCE`, 4: consecutive stable cycles required to accept a press or re-arm after a release.
- `MAX_DIGITS`, 2: decimal digits accepted per operand; further digits are ignored.
- `ALU_TIMEOUT`, 64: cycles in WAIT without `alu_done` before an error is declared.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_pressed` in 1: raw keypad press level.
- `key_code` in 4: raw key code, valid while `key_pressed` is high.
- `alu_done` in 1: one-cycle pulse from the ALU signalling that the result is valid.
- `alu_result` in 32: ALU result, sampled on `alu_done`.
- `operand_a` out 32: operand A, displayed while entering A.
- `operand_b` out 32: operand B.
- `alu_op` out 2: operator, with 0=ADD, 1=SUB, 2=MUL.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `result` out 32: latched ALU result.
- `show_result` out 1: high in state SHOW.
- `busy` out 1: high in states START and WAIT.
- `led_a` out 1: operand A is selected for entry.
- `led_b` out 1: operand B is selected for entry.
- `error` out 1: the ALU timed out; cleared by the next accepted key.

## Operation
- **Key codes.**
  - 0–9: digit.
  - 10: '+'.
  - 11: '-'.
  - 12: '*'.
  - 13: '='.
  - 14: select operand B and clear it.
  - 15: select operand A and clear it.
- **Debounce.**
  - Accept a code when `key_pressed` is high with an unchanged `key_code` for `DEBOUNCE` consecutive cycles. Acceptance produces a one-cycle internal `key_acc` pulse.
  - A code change while pressed restarts the count.
  - After an accept, no further accept occurs until `key_pressed` has been low for `DEBOUNCE` consecutive cycles. There is no auto-repeat.
- **States: ENTRY, START, WAIT, SHOW.**
- **ENTRY.**
  - Digit d: if the selected operand holds fewer than `MAX_DIGITS` digits, set operand ← operand*10 + d; otherwise ignore the key.
  - Operator key: latch `alu_op`, set `op_valid`, select B, and clear B.
  - 14 or 15: select the operand, clear it, and reset its digit count.
  - '=' with `op_valid`: go to START. Without `op_valid`: ignore.
- **START.**
  - `alu_start`=1 for exactly one cycle, then go to WAIT.
  - `operand_a`, `operand_b` and `alu_op` stay stable from START until leaving WAIT.
- **WAIT.**
  - On `alu_done`: result ← `alu_result`, go to SHOW.
  - If the timeout counter reaches `ALU_TIMEOUT` without `alu_done`: `error`=1, result=0, go to SHOW.
  - Accepted keys are dropped.
  - `alu_done` arriving outside WAIT is ignored.
- **SHOW.**
  - Digit: clear both operands, `op_valid` and the digit counts; select A; apply the digit; go to ENTRY.
  - Operator: operand A ← result (chaining), B ← 0, latch the operator, select B, go to ENTRY.
  - 14 or 15: as in ENTRY, then go to ENTRY.
  - '=': repeat the operation with the current operands. Go to START.
- **Arithmetic.** Operands are unsigned 32-bit. The digit accumulation cannot overflow for `MAX_DIGITS` ≤ 9.
- **LEDs.** `led_a` and `led_b` are always one-hot.

## Timing
- **Reset values.** All outputs are 0 except `led_a`=1. State=ENTRY. The debounce logic is re-armed.
- **Reset mid-operation.** Reset in WAIT abandons the ALU transaction. A late `alu_done` is then ignored.
- **Press to operand update.** The operand updates at cycle `DEBOUNCE`+1 after a stable press begins.
- **'=' to `alu_start`.** The '=' accept is followed by `alu_start` high on the next cycle.
- **`alu_done` to result.** `result` and `show_result` are valid the cycle after `alu_done`. `busy` falls in the same cycle.
- **`alu_done` in START's cycle.** Not possible per the ALU contract. If it occurs, it is ignored.
- **Timeout count.** Measured from the first WAIT cycle.
- **Simultaneous events.** A key accept and `alu_done` in the same cycle: `alu_done` wins and the key is dropped.

## Structure
- **Package `calc_pkg`.**
  - Key-code constants: `KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_EQ`, `KEY_SEL_B`, `KEY_SEL_A`.
  - `alu_op_t` (ADD, SUB, MUL).
  - `seq_state_t` (ENTRY, START, WAIT, SHOW).
- **Sub-module `key_debounce`.** Parameter `DEBOUNCE`. Inputs `clk`, `rst_n`, `key_pressed`, `key_code`. Outputs `key_acc` and `key_val`. The FSM and operand registers stay in `calc_sequencer`.

## Test plan
- **Bounce rejection.** Use `DEBOUNCE`=4. Toggle `key_pressed` with 3-cycle pulses of code 7 → no change to `operand_a`. Then hold it for 4 cycles → `operand_a`=7.
- **Full operation.** Press 15, 4, 2, '+', 5, 8, '='. Drive `alu_done` with result 100 three cycles after `alu_start`. Required:
  - `operand_a`=42, `operand_b`=58, `alu_op`=0.
  - `alu_start` is a single-cycle pulse and `busy`=1 during START and WAIT.
  - `result`=100 and `show_result`=1.
- **Digit cap.** Use `MAX_DIGITS`=2. Press 9, 9, 9 → operand stays at 99.
- **Chaining.** After `result`=100, press '*', 3, '='. Required: `operand_a`=100, `operand_b`=3, `alu_op`=2.
- **Timeout.** Never assert `alu_done` → after 64 WAIT cycles `error`=1 and `result`=0. The next digit press clears `error` and restarts entry in A.
- **Disruptive inputs.**
  - Pulse `rst_n` low in WAIT → all outputs return to their reset values.
  - A subsequent stray `alu_done` → no effect.
  - Key presses during WAIT → dropped.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator-mode sequencer: key codes, ALU operator
// encoding, sequencer states and small datapath helpers.
package calc_pkg;

    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_SUB   = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_EQ    = 4'd13;
    localparam logic [3:0] KEY_SEL_B = 4'd14;
    localparam logic [3:0] KEY_SEL_A = 4'd15;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } seq_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic [31:0] append_digit(input logic [31:0] val, input logic [3:0] d);
        return (val * 32'd10) + {28'd0, d};
    endfunction

    function automatic alu_op_t key_to_op(input logic [3:0] code);
        case (code)
            KEY_SUB: return SUB;
            KEY_MUL: return MUL;
            default: return ADD;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: emits a one-cycle accept pulse once a code has been held
// stable long enough, then stays disarmed until the key has been released.
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    output logic       key_acc,
    output logic [3:0] key_val
);

    localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] press_cnt_r;
    logic [CW-1:0] rel_cnt_r;
    logic [CW-1:0] press_next_s;
    logic [3:0]    code_r;
    logic [3:0]    key_val_r;
    logic          armed_r;
    logic          key_acc_r;

    // Stable-press count for this cycle; a new press or changed code restarts at one.
    always_comb begin
        press_next_s = press_cnt_r;
        if ((press_cnt_r == CNT_ZERO) || (key_code != code_r)) begin
            press_next_s = CNT_ONE;
        end else if (press_cnt_r < CNT_MAX) begin
            press_next_s = press_cnt_r + CNT_ONE;
        end else begin
            press_next_s = press_cnt_r;
        end
    end

    // Press/release counting and accept pulse generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_cnt_r <= CNT_ZERO;
            rel_cnt_r   <= CNT_ZERO;
            code_r      <= 4'd0;
            key_val_r   <= 4'd0;
            armed_r     <= 1'b1;
            key_acc_r   <= 1'b0;
        end else begin
            key_acc_r <= 1'b0;
            if (key_pressed) begin
                press_cnt_r <= press_next_s;
                code_r      <= key_code;
                rel_cnt_r   <= CNT_ZERO;
                if (armed_r && (press_next_s == CNT_MAX)) begin
                    key_acc_r <= 1'b1;
                    key_val_r <= key_code;
                    armed_r   <= 1'b0;
                end
            end else begin
                press_cnt_r <= CNT_ZERO;
                if (!armed_r) begin
                    if ((rel_cnt_r + CNT_ONE) == CNT_MAX) begin
                        armed_r   <= 1'b1;
                        rel_cnt_r <= CNT_ZERO;
                    end else begin
                        rel_cnt_r <= rel_cnt_r + CNT_ONE;
                    end
                end
            end
        end
    end

    assign key_acc = key_acc_r;
    assign key_val = key_val_r;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator-mode sequencer: assembles operands and operator from debounced keys,
// runs the shared ALU through a start/done handshake and holds the result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE    = 4,
    parameter int MAX_DIGITS  = 2,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_pressed,
    input  logic [3:0]  key_code,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    output logic [31:0] result,
    output logic        show_result,
    output logic        busy,
    output logic        led_a,
    output logic        led_b,
    output logic        error
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [DW-1:0] DIG_MAX  = DW'(MAX_DIGITS);
    localparam logic [DW-1:0] DIG_ONE  = DW'(1);
    localparam logic [DW-1:0] DIG_ZERO = {DW{1'b0}};
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic        key_acc_s;
    logic [3:0]  key_val_s;

    seq_state_t  state_r;
    alu_op_t     alu_op_r;
    logic [31:0] operand_a_r;
    logic [31:0] operand_b_r;
    logic [31:0] result_r;
    logic [DW-1:0] cnt_a_r;
    logic [DW-1:0] cnt_b_r;
    logic [TW-1:0] tmo_r;
    logic        sel_b_r;
    logic        op_valid_r;
    logic        alu_start_r;
    logic        show_r;
    logic        busy_r;
    logic        error_r;

    key_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_key_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .key_acc    (key_acc_s),
        .key_val    (key_val_s)
    );

    // Sequencer FSM with operand, operator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ENTRY;
            alu_op_r    <= ADD;
            operand_a_r <= 32'd0;
            operand_b_r <= 32'd0;
            result_r    <= 32'd0;
            cnt_a_r     <= DIG_ZERO;
            cnt_b_r     <= DIG_ZERO;
            tmo_r       <= {TW{1'b0}};
            sel_b_r     <= 1'b0;
            op_valid_r  <= 1'b0;
            alu_start_r <= 1'b0;
            show_r      <= 1'b0;
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                ENTRY: begin
                    if (key_acc_s) begin
                        error_r <= 1'b0;
                        if (is_digit(key_val_s)) begin
                            if (sel_b_r) begin
                                if (cnt_b_r < DIG_MAX) begin
                                    operand_b_r <= append_digit(operand_b_r, key_val_s);
                                    cnt_b_r     <= cnt_b_r + DIG_ONE;
                                end
                            end else if (cnt_a_r < DIG_MAX) begin
                                operand_a_r <= append_digit(operand_a_r, key_val_s);
                                cnt_a_r     <= cnt_a_r + DIG_ONE;
                            end
                        end else begin
                            case (key_val_s)
                                KEY_ADD, KEY_SUB, KEY_MUL: begin
                                    alu_op_r    <= key_to_op(key_val_s);
                                    op_valid_r  <= 1'b1;
                                    sel_b_r     <= 1'b1;
                                    operand_b_r <= 32'd0;
                                    cnt_b_r     <= DIG_ZERO;
                                end
                                KEY_EQ: begin
                                    if (op_valid_r) begin
                                        state_r     <= START;
                                        alu_start_r <= 1'b1;
                                        busy_r      <= 1'b1;
                                    end
                                end
                                KEY_SEL_B: begin
                                    sel_b_r     <= 1'b1;
                                    operand_b_r <= 32'd0;
                                    cnt_b_r     <= DIG_ZERO;
                                end
                                KEY_SEL_A: begin
                                    sel_b_r     <= 1'b0;
                                    operand_a_r <= 32'd0;
                                    cnt_a_r     <= DIG_ZERO;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                START: begin
                    alu_start_r <= 1'b0;
                    tmo_r       <= {TW{1'b0}};
                    state_r     <= WAIT;
                end
                WAIT: begin
                    // alu_done takes priority; keys accepted here are dropped.
                    if (alu_done) begin
                        result_r <= alu_result;
                        busy_r   <= 1'b0;
                        show_r   <= 1'b1;
                        state_r  <= SHOW;
                    end else if (tmo_r == TMO_LAST) begin
                        result_r <= 32'd0;
                        error_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        show_r   <= 1'b1;
                        state_r  <= SHOW;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                SHOW: begin
                    if (key_acc_s) begin
                        error_r <= 1'b0;
                        show_r  <= 1'b0;
                        state_r <= ENTRY;
                        if (is_digit(key_val_s)) begin
                            operand_a_r <= {28'd0, key_val_s};
                            operand_b_r <= 32'd0;
                            cnt_a_r     <= DIG_ONE;
                            cnt_b_r     <= DIG_ZERO;
                            op_valid_r  <= 1'b0;
                            sel_b_r     <= 1'b0;
                        end else begin
                            case (key_val_s)
                                KEY_ADD, KEY_SUB, KEY_MUL: begin
                                    // Chain: the held result becomes operand A.
                                    operand_a_r <= result_r;
                                    cnt_a_r     <= DIG_MAX;
                                    operand_b_r <= 32'd0;
                                    cnt_b_r     <= DIG_ZERO;
                                    alu_op_r    <= key_to_op(key_val_s);
                                    op_valid_r  <= 1'b1;
                                    sel_b_r     <= 1'b1;
                                end
                                KEY_EQ: begin
                                    state_r     <= START;
                                    alu_start_r <= 1'b1;
                                    busy_r      <= 1'b1;
                                end
                                KEY_SEL_B: begin
                                    sel_b_r     <= 1'b1;
                                    operand_b_r <= 32'd0;
                                    cnt_b_r     <= DIG_ZERO;
                                end
                                KEY_SEL_A: begin
                                    sel_b_r     <= 1'b0;
                                    operand_a_r <= 32'd0;
                                    cnt_a_r     <= DIG_ZERO;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: begin
                    state_r     <= ENTRY;
                    alu_start_r <= 1'b0;
                    busy_r      <= 1'b0;
                    show_r      <= 1'b0;
                end
            endcase
        end
    end

    assign operand_a   = operand_a_r;
    assign operand_b   = operand_b_r;
    assign alu_op      = alu_op_r;
    assign alu_start   = alu_start_r;
    assign result      = result_r;
    assign show_result = show_r;
    assign busy        = busy_r;
    assign led_a       = ~sel_b_r;
    assign led_b       = sel_b_r;
    assign error       = error_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer: debounce, entry, ALU handshake,
// chaining, digit cap, timeout and disruptive inputs.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_pressed = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic [31:0] result;
    logic        show_result;
    logic        busy;
    logic        led_a;
    logic        led_b;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer #(
        .DEBOUNCE   (4),
        .MAX_DIGITS (2),
        .ALU_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .result     (result),
        .show_result(show_result),
        .busy       (busy),
        .led_a      (led_a),
        .led_b      (led_b),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic key_down(input logic [3:0] code);
        key_pressed = 1'b1;
        key_code    = code;
    endtask

    task automatic key_up();
        key_pressed = 1'b0;
    endtask

    task automatic press(input logic [3:0] code);
        key_down(code);
        repeat (6) @(negedge clk);
        key_up();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_a"}, operand_a, 32'd0);
        check_eq({tag, "_b"}, operand_b, 32'd0);
        check_eq({tag, "_op"}, {30'd0, alu_op}, 32'd0);
        check_eq({tag, "_start"}, {31'd0, alu_start}, 32'd0);
        check_eq({tag, "_result"}, result, 32'd0);
        check_eq({tag, "_show"}, {31'd0, show_result}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_led_a"}, {31'd0, led_a}, 32'd1);
        check_eq({tag, "_led_b"}, {31'd0, led_b}, 32'd0);
        check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_start) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("start_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_done(input logic [31:0] val);
        alu_done   = 1'b1;
        alu_result = val;
        @(negedge clk);
        alu_done = 1'b0;
        check_eq("done_result", result, val);
        check_eq("done_show", {31'd0, show_result}, 32'd1);
        check_eq("done_busy", {31'd0, busy}, 32'd0);
    endtask

    // Press '=', check the start pulse and busy, optionally answer after 'delay' cycles.
    task automatic run_eq(input logic [31:0] val, input int delay, input bit drive);
        key_down(4'd13);
        wait_start();
        check_eq("busy_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("start_pulse", {31'd0, alu_start}, 32'd0);
        check_eq("busy_wait", {31'd0, busy}, 32'd1);
        key_up();
        if (drive) begin
            repeat (delay - 1) @(negedge clk);
            pulse_done(val);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Bounce rejection: three 3-cycle pulses, then a 4-cycle hold.
        for (int i = 0; i < 3; i++) begin
            key_down(4'd7);
            repeat (3) @(negedge clk);
            key_up();
            repeat (3) @(negedge clk);
        end
        check_eq("bounce_a", operand_a, 32'd0);
        key_down(4'd7);
        repeat (4) @(negedge clk);
        check_eq("pre_update_a", operand_a, 32'd0);
        key_up();
        @(negedge clk);
        check_eq("latency_a", operand_a, 32'd7);
        repeat (5) @(negedge clk);

        // Full operation 42 + 58.
        press(4'd15);
        check_eq("sel_a_clear", operand_a, 32'd0);
        press(4'd4);
        press(4'd2);
        check_eq("entry_a", operand_a, 32'd42);
        press(4'd10);
        check_eq("op_led_b", {31'd0, led_b}, 32'd1);
        check_eq("op_led_a", {31'd0, led_a}, 32'd0);
        press(4'd5);
        press(4'd8);
        check_eq("entry_b", operand_b, 32'd58);
        check_eq("entry_op", {30'd0, alu_op}, 32'd0);
        run_eq(32'd100, 3, 1'b1);
        check_eq("full_result", result, 32'd100);
        check_eq("full_show", {31'd0, show_result}, 32'd1);
        check_eq("full_a", operand_a, 32'd42);
        check_eq("full_b", operand_b, 32'd58);

        // Chaining: result * 3.
        press(4'd12);
        check_eq("chain_a", operand_a, 32'd100);
        check_eq("chain_b0", operand_b, 32'd0);
        check_eq("chain_show", {31'd0, show_result}, 32'd0);
        press(4'd3);
        check_eq("chain_b", operand_b, 32'd3);
        check_eq("chain_op", {30'd0, alu_op}, 32'd2);
        run_eq(32'd300, 3, 1'b1);
        check_eq("chain_result", result, 32'd300);
        check_eq("chain_a_hold", operand_a, 32'd100);

        // Digit cap, '=' without operator, operand B entry.
        press(4'd9);
        press(4'd9);
        press(4'd9);
        check_eq("cap_a", operand_a, 32'd99);
        check_eq("cap_b", operand_b, 32'd0);
        check_eq("cap_led_a", {31'd0, led_a}, 32'd1);
        press(4'd13);
        check_eq("eq_noop_busy", {31'd0, busy}, 32'd0);
        check_eq("eq_noop_show", {31'd0, show_result}, 32'd0);
        press(4'd11);
        check_eq("sub_op", {30'd0, alu_op}, 32'd1);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check_eq("cap_b12", operand_b, 32'd12);

        // Timeout: no alu_done, error after 64 WAIT cycles.
        key_down(4'd13);
        wait_start();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        check_eq("tmo_cycles", n, 32'd65);
        key_up();
        repeat (6) @(negedge clk);
        check_eq("tmo_error", {31'd0, error}, 32'd1);
        check_eq("tmo_result", result, 32'd0);
        check_eq("tmo_show", {31'd0, show_result}, 32'd1);
        check_eq("tmo_busy", {31'd0, busy}, 32'd0);
        press(4'd5);
        check_eq("tmo_clr_error", {31'd0, error}, 32'd0);
        check_eq("tmo_new_a", operand_a, 32'd5);
        check_eq("tmo_new_b", operand_b, 32'd0);
        check_eq("tmo_led_a", {31'd0, led_a}, 32'd1);

        // Reset while waiting on the ALU, then a stray alu_done.
        press(4'd10);
        press(4'd1);
        run_eq(32'd0, 0, 1'b0);
        check_eq("wait_busy", {31'd0, busy}, 32'd1);
        check_eq("wait_a", operand_a, 32'd5);
        check_eq("wait_b", operand_b, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset("midrst");
        alu_done   = 1'b1;
        alu_result = 32'd123;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        check_eq("stray_result", result, 32'd0);
        check_eq("stray_show", {31'd0, show_result}, 32'd0);
        check_eq("stray_busy", {31'd0, busy}, 32'd0);

        // Keys accepted during WAIT are dropped.
        press(4'd2);
        press(4'd10);
        press(4'd3);
        run_eq(32'd0, 0, 1'b0);
        press(4'd7);
        check_eq("drop_a", operand_a, 32'd2);
        check_eq("drop_b", operand_b, 32'd3);
        check_eq("drop_busy", {31'd0, busy}, 32'd1);
        check_eq("drop_op", {30'd0, alu_op}, 32'd0);
        pulse_done(32'd5);
        check_eq("drop_a_after", operand_a, 32'd2);
        check_eq("drop_b_after", operand_b, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
